// File: rtl/dda_param_loader_pkg.sv
// dda_param_loader_pkg: register map, ctrl bit positions, FSM states and lane helper
package dda_param_loader_pkg;

    localparam logic [2:0] A_IC1      = 3'd0;
    localparam logic [2:0] A_IC2      = 3'd1;
    localparam logic [2:0] A_VKM      = 3'd2;
    localparam logic [2:0] A_VDM      = 3'd3;
    localparam logic [2:0] A_DT       = 3'd4;
    localparam logic [2:0] A_STEPS    = 3'd5;
    localparam logic [2:0] A_PRESCALE = 3'd6;
    localparam logic [2:0] A_CTRL     = 3'd7;

    localparam int C_LOAD = 0;
    localparam int C_RUN  = 1;
    localparam int C_STOP = 2;
    localparam int C_CLR  = 3;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

    // number of byte lanes in an n-bit operand
    function automatic int lane_count(input int n);
        return n / 8;
    endfunction

endpackage

// File: rtl/dda_param_loader_sync_edge_det.sv
// sync_edge_det: two-flop synchronizer for a pin-level strobe plus rising-edge pulse
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic s1, s2, s3;

    // s1/s2 resynchronize the pin, s3 remembers the previous synchronized level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {s3, s2, s1} <= 3'b000;
        else        {s3, s2, s1} <= {s2, s1, d};
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/dda_param_loader.sv
// dda_param_loader: host byte-write register file and en/rst_n sequencer for the dda core
module dda_param_loader
    import dda_param_loader_pkg::*;
#(
    parameter int N  = 16,
    parameter int ES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   data_in,
    input  logic [2:0]   addr,
    input  logic [1:0]   lane,
    input  logic         wr,
    output logic [N-1:0] ic1,
    output logic [N-1:0] ic2,
    output logic [N-1:0] vK_M,
    output logic [N-1:0] vD_M,
    output logic [N-1:0] dt,
    output logic         dda_en,
    output logic         dda_rst_n,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int LANES = lane_count(N);

    if (!(N == 8 || N == 16 || N == 32) || ES < 0) begin : g_bad_param
        $error("dda_param_loader: N must be 8, 16 or 32 and ES non-negative");
    end

    state_t         state, state_next;
    logic [N-1:0]   ops [5];
    logic [15:0]    steps, remaining;
    logic [7:0]     prescale, prediv;
    logic           pulse, lane_ok, drop, ok, is_ctrl;
    logic           c_load, c_run, c_stop, c_clr, tick, last;

    sync_edge_det u_wr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wr),
        .pulse (pulse)
    );

    // a lane is legal only if it lies inside the addressed register's width
    always_comb begin
        lane_ok = (addr <= A_DT)    ? (32'(lane) < LANES) :
                  (addr == A_STEPS) ? (lane <= 2'd1) : (lane == 2'd0);
    end

    assign drop    = pulse & (~lane_ok | ((addr != A_CTRL) & busy));
    assign ok      = pulse & ~drop;
    assign is_ctrl = ok & (addr == A_CTRL);
    assign c_load  = is_ctrl & data_in[C_LOAD];
    assign c_run   = is_ctrl & data_in[C_RUN];
    assign c_stop  = is_ctrl & data_in[C_STOP];
    assign c_clr   = is_ctrl & data_in[C_CLR];
    assign tick    = (state == S_RUN) && (prediv == 8'd0);
    assign last    = tick && (steps != 16'd0) && (remaining == 16'd1);

    assign ic1  = ops[0];
    assign ic2  = ops[1];
    assign vK_M = ops[2];
    assign vD_M = ops[3];
    assign dt   = ops[4];

    // byte-lane writes into operand, step count and prescale registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) ops[i] <= '0;
            steps    <= '0;
            prescale <= '0;
        end else if (ok) begin
            for (int i = 0; i < 5; i++)
                for (int l = 0; l < LANES; l++)
                    if (addr == 3'(i) && lane == 2'(l)) ops[i][8*l +: 8] <= data_in;
            for (int l = 0; l < 2; l++)
                if (addr == A_STEPS && lane == 2'(l)) steps[8*l +: 8] <= data_in;
            if (addr == A_PRESCALE) prescale <= data_in;
        end
    end

    // sticky drop flag, cleared only by a CLR command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     err <= 1'b0;
        else if (c_clr) err <= 1'b0;
        else if (drop)  err <= 1'b1;
    end

    // step and prescale counters, armed on entry to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            prediv    <= '0;
        end else if (state != S_RUN && state_next == S_RUN) begin
            remaining <= steps;
            prediv    <= '0;
        end else if (tick) begin
            prediv <= prescale;
            if (steps != 16'd0) remaining <= remaining - 16'd1;
        end else if (state == S_RUN) begin
            prediv <= prediv - 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // FSM next state; STOP outranks LOAD, which outranks RUN
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE:
                state_next = (c_load && !c_stop) ? S_INIT :
                             (c_run  && !c_stop) ? S_RUN  :
                             c_clr               ? S_IDLE : state;
            S_INIT:  state_next = S_IDLE;
            S_RUN:   state_next = c_stop ? S_IDLE : last ? S_DONE : S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs; a STOP committing this cycle suppresses the pending pulse
    always_comb begin
        busy      = (state == S_INIT) || (state == S_RUN);
        done      = (state == S_DONE);
        dda_rst_n = (state != S_INIT);
        dda_en    = (state == S_INIT) || (tick && !c_stop);
    end

endmodule
